// File: rtl/pid_seq.sv
// Sequential PID steering controller: one sample walks IDLE->PTERM->ITERM->(DTERM)->SUM.
// Define PID_DTERM_EN to include the derivative stage; without it D=0 and latency is 3.
module pid_seq (
    input  logic               clk,
    input  logic               rst,
    input  logic               go,
    input  logic               err_vld,
    input  logic signed [15:0] error,
    input  logic        [10:0] frwrd_spd,
    output logic signed [11:0] lft_spd,
    output logic signed [11:0] rght_spd,
    output logic               spd_vld,
    output logic               busy,
    output logic               ovr
);

`ifdef PID_DTERM_EN
    typedef enum logic [2:0] {IDLE, PTERM, ITERM, DTERM, SUM} state_t;
`else
    typedef enum logic [2:0] {IDLE, PTERM, ITERM, SUM} state_t;
`endif

    state_t state_q, state_d;

    logic signed [10:0] err_sat_q, err_sat_d;
    logic signed [14:0] p_q, p_d;
    logic signed [15:0] integ_q, integ_d;
    logic signed [11:0] lft_q, lft_d;
    logic signed [11:0] rght_q, rght_d;
    logic               spd_vld_q, spd_vld_d;
    logic               ovr_q, ovr_d;
`ifdef PID_DTERM_EN
    logic signed [14:0] d_q, d_d;
    logic signed [10:0] prev_err_q, prev_err_d;
    logic signed [11:0] diff_raw;
    logic signed [8:0]  diff_sat;
`endif

    logic               capture;
    logic signed [10:0] err_in_sat;
    logic signed [16:0] integ_sum;
    logic signed [10:0] mul_a;
    logic signed [3:0]  mul_b;
    logic signed [14:0] mul_p;
    logic signed [16:0] pid;
    logic signed [16:0] corr;
    logic signed [17:0] lft_raw;
    logic signed [17:0] rght_raw;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = IDLE;
        if (go) begin
            case (state_q)
                IDLE:    state_d = (err_vld) ? PTERM : IDLE;
                PTERM:   state_d = ITERM;
`ifdef PID_DTERM_EN
                ITERM:   state_d = DTERM;
                DTERM:   state_d = SUM;
`else
                ITERM:   state_d = SUM;
`endif
                SUM:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        busy      = (state_q != IDLE);
        capture   = go && err_vld && (state_q == IDLE);
        spd_vld_d = go && (state_q == SUM);
    end

    // The single multiplier: err_sat*2 in PTERM, diff*5 in DTERM
    always_comb begin
        mul_a = err_sat_q;
        mul_b = 4'sd2;
`ifdef PID_DTERM_EN
        diff_raw = 12'(err_sat_q) - 12'(prev_err_q);
        if (diff_raw > 12'sd255) begin
            diff_sat = 9'sd255;
        end else if (diff_raw < -12'sd256) begin
            diff_sat = -9'sd256;
        end else begin
            diff_sat = diff_raw[8:0];
        end
        if (state_q == DTERM) begin
            mul_a = 11'(diff_sat);
            mul_b = 4'sd5;
        end
`endif
        mul_p = 15'(mul_a) * 15'(mul_b);
    end

    always_comb begin
        if (error > 16'sd1023) begin
            err_in_sat = 11'sd1023;
        end else if (error < -16'sd1024) begin
            err_in_sat = -11'sd1024;
        end else begin
            err_in_sat = error[10:0];
        end

        integ_sum = 17'(integ_q) + 17'(err_sat_q);

`ifdef PID_DTERM_EN
        pid = 17'(p_q) + 17'(integ_q >>> 4) + 17'(d_q);
`else
        pid = 17'(p_q) + 17'(integ_q >>> 4);
`endif
        corr     = pid >>> 3;
        lft_raw  = $signed({7'd0, frwrd_spd}) + 18'(corr);
        rght_raw = $signed({7'd0, frwrd_spd}) - 18'(corr);
    end

    // Datapath next values; go low wipes history and forces outputs to zero
    always_comb begin
        err_sat_d = capture ? err_in_sat : err_sat_q;
        p_d       = (state_q == PTERM) ? mul_p : p_q;
        integ_d   = integ_q;
        lft_d     = lft_q;
        rght_d    = rght_q;
        ovr_d     = ovr_q | (go && err_vld && busy);
`ifdef PID_DTERM_EN
        d_d        = (state_q == DTERM) ? mul_p : d_q;
        prev_err_d = (state_q == DTERM) ? err_sat_q : prev_err_q;
`endif
        if (state_q == ITERM) begin
            if (integ_sum > 17'sd32767) begin
                integ_d = 16'sh7FFF;
            end else if (integ_sum < -17'sd32768) begin
                integ_d = 16'sh8000;
            end else begin
                integ_d = integ_sum[15:0];
            end
        end
        if (state_q == SUM) begin
            if (lft_raw > 18'sd2047) begin
                lft_d = 12'sd2047;
            end else if (lft_raw < -18'sd2048) begin
                lft_d = -12'sd2048;
            end else begin
                lft_d = lft_raw[11:0];
            end
            if (rght_raw > 18'sd2047) begin
                rght_d = 12'sd2047;
            end else if (rght_raw < -18'sd2048) begin
                rght_d = -12'sd2048;
            end else begin
                rght_d = rght_raw[11:0];
            end
        end
        if (!go) begin
            integ_d = '0;
            lft_d   = '0;
            rght_d  = '0;
            ovr_d   = 1'b0;
`ifdef PID_DTERM_EN
            prev_err_d = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_sat_q  <= '0;
            p_q        <= '0;
            integ_q    <= '0;
            lft_q      <= '0;
            rght_q     <= '0;
            spd_vld_q  <= 1'b0;
            ovr_q      <= 1'b0;
`ifdef PID_DTERM_EN
            d_q        <= '0;
            prev_err_q <= '0;
`endif
        end else begin
            err_sat_q  <= err_sat_d;
            p_q        <= p_d;
            integ_q    <= integ_d;
            lft_q      <= lft_d;
            rght_q     <= rght_d;
            spd_vld_q  <= spd_vld_d;
            ovr_q      <= ovr_d;
`ifdef PID_DTERM_EN
            d_q        <= d_d;
            prev_err_q <= prev_err_d;
`endif
        end
    end

    assign lft_spd  = lft_q;
    assign rght_spd = rght_q;
    assign spd_vld  = spd_vld_q;
    assign ovr      = ovr_q;

endmodule

// File: tb/tb_pid_seq.sv
// Self-checking bench for pid_seq: vector table plus scoreboarded corner-case sequences.
// Expected values follow PID_DTERM_EN the same way the design does.
module tb_pid_seq;

`ifdef PID_DTERM_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               go;
    logic               err_vld;
    logic signed [15:0] error;
    logic        [10:0] frwrd_spd;
    logic signed [11:0] lft_spd;
    logic signed [11:0] rght_spd;
    logic               spd_vld;
    logic               busy;
    logic               ovr;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int lft;
        int rght;
        int due;
    } exp_t;

    typedef struct {
        logic signed [15:0] err;
        logic        [10:0] fw;
        int                 lft;
        int                 rght;
    } vec_t;

    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[7];
    int   m_integ;
    int   m_prev;

    pid_seq dut (
        .clk       (clk),
        .rst       (rst),
        .go        (go),
        .err_vld   (err_vld),
        .error     (error),
        .frwrd_spd (frwrd_spd),
        .lft_spd   (lft_spd),
        .rght_spd  (rght_spd),
        .spd_vld   (spd_vld),
        .busy      (busy),
        .ovr       (ovr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    // Reference arithmetic taken directly from the controller's definition
    task automatic model_sample(input int e, input int fw, output int l, output int r);
        int es, p, i, d, pid, corr;
        es      = clamp(e, -1024, 1023);
        p       = es * 2;
        m_integ = clamp(m_integ + es, -32768, 32767);
        i       = m_integ >>> 4;
        d       = 0;
`ifdef PID_DTERM_EN
        begin
            int diff;
            diff   = clamp(es - m_prev, -256, 255);
            d      = diff * 5;
            m_prev = es;
        end
`endif
        pid  = p + i + d;
        corr = pid >>> 3;
        l    = clamp(fw + corr, -2048, 2047);
        r    = clamp(fw - corr, -2048, 2047);
    endtask

    // Called at a falling edge; err_vld is sampled on the following rising edge
    task automatic pulse_err(input logic signed [15:0] e, input logic [10:0] fw);
        error     = e;
        frwrd_spd = fw;
        err_vld   = 1'b1;
        @(negedge clk);
        err_vld   = 1'b0;
    endtask

    task automatic send_model(input logic signed [15:0] e, input logic [10:0] fw);
        int l, r;
        model_sample(int'(e), int'(fw), l, r);
        sb_q.push_back('{l, r, cyc + 1 + LAT});
        pulse_err(e, fw);
    endtask

    task automatic drain();
        int k = 0;
        while (sb_q.size() != 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("drain_pending", sb_q.size(), 0);
        sb_q.delete();
        @(negedge clk);
    endtask

    task automatic fresh();
        go = 1'b0;
        @(negedge clk);
        check("golow_lft", int'(lft_spd), 0);
        go      = 1'b1;
        m_integ = 0;
        m_prev  = 0;
    endtask

    always @(negedge clk) begin
        if (spd_vld) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spd_vld_unexpected: got pulse at cycle %0d, expected none", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                check("lft_spd", int'(lft_spd), mon_e.lft);
                check("rght_spd", int'(rght_spd), mon_e.rght);
                check("latency", cyc, mon_e.due);
                $display("txn cyc=%0d lft_spd=%0d rght_spd=%0d", cyc, lft_spd, rght_spd);
            end
        end
    end

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL timeout: got no finish by cycle %0d, expected completion", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
`ifdef PID_DTERM_EN
        vecs[0] = '{16'sd256,   11'd256,  481,   31};
        vecs[1] = '{16'sh7FFF,  11'd0,    423, -423};
        vecs[2] = '{16'sd0,     11'd100,  100,  100};
        vecs[3] = '{-16'sd1,    11'd500,  499,  501};
        vecs[4] = '{16'sh8000,  11'd0,   -424,  424};
        vecs[5] = '{-16'sd100,  11'd2047, 1958, 2047};
        vecs[6] = '{16'sd8,     11'd0,    7,    -7};
`else
        vecs[0] = '{16'sd256,   11'd256,  322,  190};
        vecs[1] = '{16'sh7FFF,  11'd0,    263, -263};
        vecs[2] = '{16'sd0,     11'd100,  100,  100};
        vecs[3] = '{-16'sd1,    11'd500,  499,  501};
        vecs[4] = '{16'sh8000,  11'd0,   -264,  264};
        vecs[5] = '{-16'sd100,  11'd2047, 2021, 2047};
        vecs[6] = '{16'sd8,     11'd0,    2,    -2};
`endif
        rst = 1'b1; go = 1'b0; err_vld = 1'b0; error = '0; frwrd_spd = '0;
        m_integ = 0; m_prev = 0;
        repeat (3) @(negedge clk);
        check("rst_lft", int'(lft_spd), 0);
        check("rst_rght", int'(rght_spd), 0);
        check("rst_spd_vld", int'(spd_vld), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ovr", int'(ovr), 0);
        rst = 1'b0;

        // err_vld with go low is ignored
        pulse_err(16'sd300, 11'd50);
        check("golow_busy", int'(busy), 0);
        check("golow_ovr", int'(ovr), 0);
        repeat (LAT + 2) @(negedge clk);

        // Vector table, each from a cleared integrator/prev_err
        for (int i = 0; i < 7; i++) begin
            fresh();
            sb_q.push_back('{vecs[i].lft, vecs[i].rght, cyc + 1 + LAT});
            pulse_err(vecs[i].err, vecs[i].fw);
            check("busy_running", int'(busy), 1);
            drain();
            check("hold_lft", int'(lft_spd), vecs[i].lft);
        end

        // Second strobe two clocks after the first is dropped and flags ovr
        fresh();
        send_model(16'sd256, 11'd256);
        @(negedge clk);
        pulse_err(-16'sd700, 11'd256);
        drain();
        check("overlap_ovr", int'(ovr), 1);

        // Strobe during the SUM cycle is dropped; later samples are unaffected
        fresh();
        send_model(16'sd100, 11'd400);
        repeat (LAT - 1) @(negedge clk);
        check("sum_busy", int'(busy), 1);
        pulse_err(16'sd900, 11'd400);
        drain();
        check("sum_ovr", int'(ovr), 1);
        send_model(16'sd40, 11'd400);
        drain();

        // go falls during ITERM: abort, clear, next sample behaves as the first
        send_model(16'sd256, 11'd256);
        pulse_err(16'sd10, 11'd256);
        check("abort_ovr_set", int'(ovr), 1);
        go = 1'b0;
        void'(sb_q.pop_back());
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_lft", int'(lft_spd), 0);
        check("abort_rght", int'(rght_spd), 0);
        check("abort_ovr", int'(ovr), 0);
        go = 1'b1; m_integ = 0; m_prev = 0;
        repeat (LAT + 2) @(negedge clk);
        send_model(16'sd256, 11'd256);
        drain();
        check("first_again_lft", int'(lft_spd), vecs[0].lft);

        // rst during PTERM with go high
        send_model(16'sd256, 11'd256);
        rst = 1'b1;
        void'(sb_q.pop_back());
        @(negedge clk);
        check("rstmid_lft", int'(lft_spd), 0);
        check("rstmid_rght", int'(rght_spd), 0);
        check("rstmid_busy", int'(busy), 0);
        check("rstmid_spd_vld", int'(spd_vld), 0);
        rst = 1'b0; m_integ = 0; m_prev = 0;
        repeat (LAT + 2) @(negedge clk);

        // Long run at full-scale error: integrator and outputs saturate, no wrap
        fresh();
        for (int n = 0; n < 2100; n++) begin
            send_model(16'sh03FF, 11'd2047);
            drain();
        end
        check("sat_integ_model", m_integ, 32767);
        check("sat_lft", int'(lft_spd), 2047);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
